// File: rtl/dom_mask_feeder.sv
// Masked-operand and DOM randomness source for the shared GF(2^2) multiplier.
// One Galois LFSR feeds share masks and Z bits; operands pass a 1-deep skid.
module dom_mask_feeder #(
  parameter int unsigned SHARES = 2,
  parameter logic [31:0] SEED   = 32'hACE1_2468,
  parameter int unsigned WARMUP = 32
) (
  input  logic                         ClkxCI,
  input  logic                         RstxBI,
  input  logic [31:0]                  SeedxDI,
  input  logic                         SeedValidxSI,
  input  logic [1:0]                   XxDI,
  input  logic [1:0]                   YxDI,
  input  logic                         InValidxSI,
  output logic                         InReadyxSO,
  output logic [2*SHARES-1:0]          _XxDO,
  output logic [2*SHARES-1:0]          _YxDO,
  output logic [2*SHARES-1:0]          _BxDO,
  output logic [SHARES*(SHARES-1)-1:0] _ZxDO,
  output logic                         OutValidxSO,
  input  logic                         OutReadyxSI
);

  localparam int unsigned RW = 2 * (SHARES - 1);
  localparam int unsigned ZW = SHARES * (SHARES - 1);
  localparam int unsigned SW = 2 * SHARES;
  localparam int unsigned CW =
    (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WARMUP - 1);
  // x^32+x^22+x^2+x+1 in right-shifting Galois form
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef enum logic {
    stWarmup,
    stRun
  } state_t;

  state_t        state;
  state_t        stateNxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cntNxt;
  logic [31:0]   lfsr;
  logic [31:0]   lfsrStep;
  logic [31:0]   lfsrNxt;

  logic          outValid;
  logic          inReady;
  logic          fire;

  logic [SW-1:0] xReg;
  logic [SW-1:0] yReg;
  logic [ZW-1:0] zReg;
  logic [SW-1:0] xShNxt;
  logic [SW-1:0] yShNxt;
  logic [ZW-1:0] zNxt;
  logic [1:0]    xAcc;
  logic [1:0]    yAcc;

  always_comb begin
    lfsrStep = lfsr[0] ? ((lfsr >> 1) ^ TAPS)
                       : (lfsr >> 1);
    lfsrNxt  = lfsrStep;
    if (SeedValidxSI) begin
      lfsrNxt = (SeedxDI != '0) ? SeedxDI : SEED;
    end
    if (lfsrNxt == '0) begin
      lfsrNxt = SEED;
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      lfsr <= SEED;
    end else begin
      lfsr <= lfsrNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    if (SeedValidxSI) begin
      stateNxt = stWarmup;
      cntNxt   = '0;
    end else begin
      unique case (state)
        stWarmup: begin
          if (cnt == CNT_LAST) begin
            stateNxt = stRun;
            cntNxt   = '0;
          end else begin
            cntNxt = cnt + 1'b1;
          end
        end
        stRun: begin
          stateNxt = stRun;
        end
        default: begin
          stateNxt = stWarmup;
          cntNxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      state <= stWarmup;
      cnt   <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  assign inReady = (state == stRun)
                && (!outValid || OutReadyxSI);
  // a reseed in the same cycle swallows the offered beat
  assign fire    = InValidxSI && inReady
                && !SeedValidxSI;

  always_comb begin
    xShNxt = '0;
    yShNxt = '0;
    xAcc   = XxDI;
    yAcc   = YxDI;
    for (int k = 0; k < SHARES - 1; k++) begin
      xShNxt[2*k +: 2] = lfsr[2*k +: 2];
      yShNxt[2*k +: 2] = lfsr[RW + 2*k +: 2];
      xAcc = xAcc ^ lfsr[2*k +: 2];
      yAcc = yAcc ^ lfsr[RW + 2*k +: 2];
    end
    xShNxt[SW-2 +: 2] = xAcc;
    yShNxt[SW-2 +: 2] = yAcc;
    zNxt = lfsr[2*RW +: ZW];
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      outValid <= 1'b0;
      xReg     <= '0;
      yReg     <= '0;
      zReg     <= '0;
    end else if (SeedValidxSI) begin
      outValid <= 1'b0;
    end else if (fire) begin
      outValid <= 1'b1;
      xReg     <= xShNxt;
      yReg     <= yShNxt;
      zReg     <= zNxt;
    end else if (OutReadyxSI) begin
      outValid <= 1'b0;
    end
  end

  assign InReadyxSO  = inReady;
  assign OutValidxSO = outValid;
  assign _XxDO       = xReg;
  assign _YxDO       = yReg;
  assign _BxDO       = yReg;
  assign _ZxDO       = zReg;

endmodule
